// File: rtl/lcd_hd44780_rx.sv
// rtl/lcd_hd44780_rx.sv - HD44780-compatible panel-side receiver for the 4/8-bit LCD bus with a 2x40 DDRAM model
module lcd_hd44780_rx #(
  parameter int BUSY_CYC = 2000,
  parameter int NIB_GAP  = 50,
  parameter int EN_MIN   = 12,
  parameter int CLR_CYC  = 80
) (
  input  logic       iMClk,
  input  logic       iMRst,
  input  logic       iLcdRegSel,
  input  logic       iLcdRW,
  input  logic       iLcdEn,
  input  logic [7:0] iLcdDb,
  input  logic       iRdLine,
  input  logic [5:0] iRdCol,
  output logic [7:0] oRdData,
  output logic       oFourBit,
  output logic       oDispOn,
  output logic       oEntryInc,
  output logic [6:0] oAddr,
  output logic       oCmdValid,
  output logic [8:0] oCmd,
  output logic       oBusy,
  output logic       oErrTiming,
  output logic       oErrProto
);

  localparam logic [11:0] BUSY_LIM = 12'(BUSY_CYC);
  localparam logic [11:0] NIB_LIM  = 12'(NIB_GAP);
  localparam logic [11:0] EN_LIM   = 12'(EN_MIN);
  localparam logic [6:0]  CLR_LAST = 7'(CLR_CYC - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} clrState_t;
  clrState_t state, nextState;

  logic [7:0]  ddram [0:79];
  logic        enQ, enQd, rsQ, rwQ;
  logic [7:0]  dbQ;
  logic        phaseLo;
  logic [3:0]  hiNib;
  logic [11:0] busyTmr, nibTmr, enHighCnt;
  logic [6:0]  clrCnt;
  logic        enFall, enRise, byteDone, hiDone, startClr, clearDone, colBad;
  logic [7:0]  byteNow, execByte;
  logic        execRs;
  logic [6:0]  addrStep;

  // Line 1 cells follow line 0 cells in the flat array: index = line*40 + col.
  function automatic logic [6:0] cellIdx(input logic [6:0] addr);
    return addr[6] ? ({1'b0, addr[5:0]} + 7'd40) : {1'b0, addr[5:0]};
  endfunction

  assign enFall    = enQd & ~enQ;
  assign enRise    = enQ & ~enQd;
  assign byteNow   = oFourBit ? {hiNib, dbQ[7:4]} : dbQ;
  assign byteDone  = enFall & ~rwQ & (~oFourBit | phaseLo);
  assign hiDone    = enFall & ~rwQ & oFourBit & ~phaseLo;
  assign execRs    = oCmd[8];
  assign execByte  = oCmd[7:0];
  assign startClr  = oCmdValid & ~execRs & (execByte == 8'h01);
  assign clearDone = (state == ST_CLEAR) && (clrCnt == CLR_LAST) && !startClr;
  assign colBad    = oAddr[5:0] >= 6'd40;
  assign oBusy     = (state == ST_CLEAR);

  always_comb begin
    addrStep = oEntryInc ? oAddr + 7'd1 : oAddr - 7'd1;
    if (oEntryInc && oAddr == 7'h27)       addrStep = 7'h40;
    else if (oEntryInc && oAddr == 7'h67)  addrStep = 7'h00;
    else if (!oEntryInc && oAddr == 7'h00) addrStep = 7'h67;
    else if (!oEntryInc && oAddr == 7'h40) addrStep = 7'h27;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:  if (startClr) nextState = ST_CLEAR;
      ST_CLEAR: if (clearDone) nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge iMClk or posedge iMRst) begin
    if (iMRst) state <= ST_IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge iMClk or posedge iMRst) begin
    if (iMRst) begin
      enQ        <= 1'b0;
      enQd       <= 1'b0;
      rsQ        <= 1'b0;
      rwQ        <= 1'b0;
      dbQ        <= 8'h00;
      phaseLo    <= 1'b0;
      hiNib      <= 4'h0;
      busyTmr    <= BUSY_LIM;
      nibTmr     <= NIB_LIM;
      enHighCnt  <= EN_LIM;
      clrCnt     <= 7'd0;
      oRdData    <= 8'h00;
      oFourBit   <= 1'b0;
      oDispOn    <= 1'b0;
      oEntryInc  <= 1'b1;
      oAddr      <= 7'd0;
      oCmdValid  <= 1'b0;
      oCmd       <= 9'h000;
      oErrTiming <= 1'b0;
      oErrProto  <= 1'b0;
      for (int i = 0; i < 80; i++) ddram[i] <= 8'h20;
    end else begin
      enQ  <= iLcdEn;
      enQd <= enQ;
      rsQ  <= iLcdRegSel;
      rwQ  <= iLcdRW;
      dbQ  <= iLcdDb;

      // Timers start expired so the first strobe after reset is never flagged.
      if (enRise) enHighCnt <= 12'd1;
      else if (enQ && enHighCnt != EN_LIM) enHighCnt <= enHighCnt + 12'd1;
      if (byteDone) busyTmr <= 12'd1;
      else if (busyTmr != BUSY_LIM) busyTmr <= busyTmr + 12'd1;
      if (hiDone) nibTmr <= 12'd1;
      else if (nibTmr != NIB_LIM) nibTmr <= nibTmr + 12'd1;

      if (enRise && (busyTmr < BUSY_LIM || nibTmr < NIB_LIM)) oErrTiming <= 1'b1;
      if (enFall && enHighCnt < EN_LIM) oErrTiming <= 1'b1;
      if (oCmdValid && oBusy) oErrTiming <= 1'b1;
      if (enFall && rwQ) oErrProto <= 1'b1;

      if (hiDone) begin
        hiNib   <= dbQ[7:4];
        phaseLo <= 1'b1;
      end else if (byteDone) begin
        phaseLo <= 1'b0;
      end
      oCmdValid <= byteDone;
      if (byteDone) oCmd <= {rsQ, byteNow};

      if (startClr) clrCnt <= 7'd0;
      else if (oBusy) clrCnt <= clrCnt + 7'd1;
      if (oBusy) ddram[clrCnt] <= 8'h20;
      if (clearDone) begin
        oAddr     <= 7'd0;
        oEntryInc <= 1'b1;
      end

      // Executed byte comes last so a data write during clear wins its cell.
      if (oCmdValid) begin
        if (execRs) begin
          if (colBad) oErrProto <= 1'b1;
          else begin
            ddram[cellIdx(oAddr)] <= execByte;
            oAddr <= addrStep;
          end
        end else begin
          casez (execByte)
            8'b1???????: begin
              oAddr <= execByte[6:0];
              if (execByte[5:0] >= 6'd40) oErrProto <= 1'b1;
            end
            8'b01??????: ;
            8'b001?????: begin
              oFourBit <= ~execByte[4];
              if (!execByte[4]) phaseLo <= 1'b0;
            end
            8'b0001????: ;
            8'b00001???: oDispOn <= execByte[2];
            8'b000001??: oEntryInc <= execByte[1];
            8'b0000001?: oAddr <= 7'd0;
            default: ;
          endcase
        end
      end

      oRdData <= (iRdCol >= 6'd40) ? 8'h20 : ddram[cellIdx({iRdLine, iRdCol})];
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// tb/tb_lcd_hd44780_rx.sv - randomized self-checking bench for lcd_hd44780_rx against a panel model
`timescale 1ns/1ps
module tb_lcd_hd44780_rx;
  localparam int BYTE_GAP = 2050;
  localparam int NIB_OK   = 60;

  logic       iMClk = 1'b0;
  logic       iMRst, iLcdRegSel, iLcdRW, iLcdEn, iRdLine;
  logic [7:0] iLcdDb;
  logic [5:0] iRdCol;
  logic [7:0] oRdData;
  logic       oFourBit, oDispOn, oEntryInc, oCmdValid, oBusy, oErrTiming, oErrProto;
  logic [6:0] oAddr;
  logic [8:0] oCmd;

  int checks = 0;
  int errors = 0;

  logic [7:0] mMem [0:1][0:39];
  logic       mFourBit, mDispOn, mEntryInc, mErrT, mErrP;
  logic [6:0] mAddr;
  int         validCnt, busyCnt;
  logic [8:0] lastCmd;

  lcd_hd44780_rx dut (
    .iMClk(iMClk), .iMRst(iMRst), .iLcdRegSel(iLcdRegSel), .iLcdRW(iLcdRW),
    .iLcdEn(iLcdEn), .iLcdDb(iLcdDb), .iRdLine(iRdLine), .iRdCol(iRdCol),
    .oRdData(oRdData), .oFourBit(oFourBit), .oDispOn(oDispOn), .oEntryInc(oEntryInc),
    .oAddr(oAddr), .oCmdValid(oCmdValid), .oCmd(oCmd), .oBusy(oBusy),
    .oErrTiming(oErrTiming), .oErrProto(oErrProto)
  );

  always #10 iMClk = ~iMClk;

  task automatic modelReset();
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 40; c++) mMem[l][c] = 8'h20;
    mFourBit = 0; mDispOn = 0; mEntryInc = 1; mErrT = 0; mErrP = 0; mAddr = 7'h00;
  endtask

  // The 80 visible cells form one ring: positions 0..39 on line 0, 40..79 on line 1.
  function automatic logic [6:0] posToAddr(input int p);
    return (p >= 40) ? 7'(64 + p - 40) : 7'(p);
  endfunction

  task automatic modelByte(input logic rs, input logic [7:0] b);
    int p;
    if (rs) begin
      if (mAddr[5:0] >= 6'd40) mErrP = 1;
      else begin
        mMem[mAddr[6]][mAddr[5:0]] = b;
        p = (mAddr[6] ? 40 : 0) + int'(mAddr[5:0]);
        p = mEntryInc ? (p + 1) % 80 : (p + 79) % 80;
        mAddr = posToAddr(p);
      end
    end
    else if (b[7]) begin mAddr = b[6:0]; if (b[5:0] >= 6'd40) mErrP = 1; end
    else if (b[6]) ;
    else if (b[5]) mFourBit = ~b[4];
    else if (b[4]) ;
    else if (b[3]) mDispOn = b[2];
    else if (b[2]) mEntryInc = b[1];
    else if (b[1]) mAddr = 7'h00;
    else if (b[0]) begin
      for (int l = 0; l < 2; l++)
        for (int c = 0; c < 40; c++) mMem[l][c] = 8'h20;
      mAddr = 7'h00; mEntryInc = 1;
    end
  endtask

  task automatic tick();
    @(posedge iMClk); #1;
    if (oCmdValid) begin validCnt++; lastCmd = oCmd; end
    if (oBusy) busyCnt++;
  endtask

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] db, input int gap);
    iLcdRegSel = rs; iLcdRW = rw; iLcdDb = db;
    repeat (2) tick();
    iLcdEn = 1'b1;
    repeat (20) tick();
    iLcdEn = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic sendByte(input logic rs, input logic [7:0] b, input int nibGap);
    logic fb;
    fb = mFourBit;
    validCnt = 0; busyCnt = 0; lastCmd = 9'h000;
    if (fb) begin
      strobe(rs, 1'b0, {b[7:4], 4'($urandom)}, nibGap);
      strobe(rs, 1'b0, {b[3:0], 4'($urandom)}, BYTE_GAP);
      if (nibGap + 2 < 50) mErrT = 1;
    end else begin
      strobe(rs, 1'b0, b, BYTE_GAP);
    end
    modelByte(rs, b);
    checks++;
    if (validCnt !== 1 || lastCmd !== {rs, b}) begin
      errors++;
      $display("FAIL cmd_pulse: got %0d pulses cmd %h, want 1 pulse cmd %h", validCnt, lastCmd, {rs, b});
    end
    checks++;
    if (busyCnt !== ((!rs && b == 8'h01) ? 80 : 0)) begin
      errors++;
      $display("FAIL busy_len: got %0d cycles, want %0d", busyCnt, (!rs && b == 8'h01) ? 80 : 0);
    end
  endtask

  task automatic test_ddram(input string tag);
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 40; c++) begin
        iRdLine = l[0]; iRdCol = 6'(c); tick();
        checks++;
        if (oRdData !== mMem[l][c]) begin
          errors++;
          $display("FAIL %s cell[%0d][%0d]: got %h want %h", tag, l, c, oRdData, mMem[l][c]);
        end
      end
    for (int k = 0; k < 4; k++) begin
      iRdLine = 1'($urandom); iRdCol = 6'($urandom_range(40, 63)); tick();
      checks++;
      if (oRdData !== 8'h20) begin
        errors++;
        $display("FAIL %s read_col_oob: got %h want 20", tag, oRdData);
      end
    end
  endtask

  task automatic test_reset();
    iMRst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({oRdData, oFourBit, oDispOn, oEntryInc, oAddr, oCmdValid, oCmd, oBusy, oErrTiming, oErrProto}
        !== {8'h00, 1'b0, 1'b0, 1'b1, 7'h00, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got addr %h inc %b four %b cmd %h", oAddr, oEntryInc, oFourBit, oCmd);
    end
    iMRst = 1'b0;
    modelReset();
    test_ddram("reset_fill");
  endtask

  task automatic test_init();
    logic [3:0] nib [4] = '{4'h3, 4'h3, 4'h3, 4'h2};
    for (int i = 0; i < 4; i++) sendByte(1'b0, {nib[i], 4'($urandom)}, NIB_OK);
    checks++;
    if (oFourBit !== 1'b1 || oErrTiming !== 1'b0 || oErrProto !== 1'b0) begin
      errors++;
      $display("FAIL init: got four %b errT %b errP %b, want 1 0 0", oFourBit, oErrTiming, oErrProto);
    end
  endtask

  task automatic test_config();
    logic [7:0] seq [4] = '{8'h28, 8'h06, 8'h0C, 8'h01};
    for (int i = 0; i < 4; i++) sendByte(1'b0, seq[i], NIB_OK);
    checks++;
    if ({oFourBit, oDispOn, oEntryInc, oAddr} !== {1'b1, 1'b1, 1'b1, 7'h00}) begin
      errors++;
      $display("FAIL config: got four %b disp %b inc %b addr %h", oFourBit, oDispOn, oEntryInc, oAddr);
    end
    test_ddram("after_clear");
  endtask

  task automatic test_boundary();
    logic [7:0] setA [4] = '{8'h80, 8'hC0, 8'hA7, 8'hE7};
    logic [6:0] expA [4] = '{7'h67, 7'h27, 7'h40, 7'h00};
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) sendByte(1'b0, 8'h04, NIB_OK);
      if (i == 2) sendByte(1'b0, 8'h06, NIB_OK);
      sendByte(1'b0, setA[i], NIB_OK);
      d = (i == 2) ? 8'h41 : 8'($urandom_range(33, 126));
      sendByte(1'b1, d, NIB_OK);
      checks++;
      if (oAddr !== expA[i] || oAddr !== mAddr) begin
        errors++;
        $display("FAIL addr_wrap_%0d: got %h want %h", i, oAddr, expA[i]);
      end
    end
    iRdLine = 1'b0; iRdCol = 6'd39; tick();
    checks++;
    if (oRdData !== 8'h41) begin
      errors++;
      $display("FAIL write_col39: got %h want 41", oRdData);
    end
  endtask

  task automatic test_random();
    logic [6:0] a;
    for (int i = 0; i < 2; i++) begin
      a = {1'($urandom), 6'($urandom_range(0, 39))};
      sendByte(1'b0, {1'b1, a}, NIB_OK);
      sendByte(1'b1, 8'($urandom), NIB_OK);
      sendByte(1'b1, 8'($urandom), NIB_OK);
      checks++;
      if ({oAddr, oErrTiming, oErrProto} !== {mAddr, mErrT, mErrP}) begin
        errors++;
        $display("FAIL random_%0d: got addr %h errT %b errP %b want %h %b %b", i, oAddr, oErrTiming, oErrProto, mAddr, mErrT, mErrP);
      end
    end
    test_ddram("random_writes");
  endtask

  task automatic test_nib_timing();
    logic [6:0] a;
    a = mAddr;
    sendByte(1'b1, 8'($urandom), 18);
    checks++;
    if (oErrTiming !== 1'b1 || mErrT !== 1'b1) begin
      errors++;
      $display("FAIL nib_gap: got errT %b want 1", oErrTiming);
    end
    iRdLine = a[6]; iRdCol = a[5:0]; tick();
    checks++;
    if (oRdData !== mMem[a[6]][a[5:0]]) begin
      errors++;
      $display("FAIL nib_gap_write: got %h want %h", oRdData, mMem[a[6]][a[5:0]]);
    end
  endtask

  task automatic test_proto();
    checks++;
    if (oErrProto !== 1'b0) begin
      errors++;
      $display("FAIL proto_pre: got %b want 0", oErrProto);
    end
    sendByte(1'b0, 8'hA8, NIB_OK);
    sendByte(1'b1, 8'($urandom), NIB_OK);
    checks++;
    if (oErrProto !== 1'b1 || oAddr !== 7'h28) begin
      errors++;
      $display("FAIL proto_col40: got errP %b addr %h want 1 28", oErrProto, oAddr);
    end
    test_ddram("col40_drop");
    validCnt = 0;
    strobe(1'b0, 1'b1, 8'($urandom), NIB_OK);
    checks++;
    if (validCnt !== 0) begin
      errors++;
      $display("FAIL rw_strobe: got %0d pulses want 0", validCnt);
    end
    sendByte(1'b0, 8'h85, NIB_OK);
    checks++;
    if (oAddr !== 7'h05 || oErrTiming !== mErrT) begin
      errors++;
      $display("FAIL rw_phase: got addr %h errT %b want 05 %b", oAddr, oErrTiming, mErrT);
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [3:0] r;
    strobe(1'b0, 1'b0, {4'h4, 4'($urandom)}, 5);
    #3 iMRst = 1'b1;
    #1;
    checks++;
    if ({oFourBit, oDispOn, oEntryInc, oAddr, oErrTiming, oErrProto, oBusy}
        !== {1'b0, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got four %b disp %b inc %b addr %h errT %b errP %b", oFourBit, oDispOn, oEntryInc, oAddr, oErrTiming, oErrProto);
    end
    repeat (2) tick();
    iMRst = 1'b0;
    modelReset();
    r = 4'($urandom);
    validCnt = 0;
    strobe(1'b0, 1'b0, {4'h8, r}, 40);
    checks++;
    if (validCnt !== 1 || lastCmd !== {1'b0, 4'h8, r} || oAddr !== {3'b000, r} || oFourBit !== 1'b0 || oErrTiming !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_byte: got %0d pulses cmd %h addr %h four %b errT %b", validCnt, lastCmd, oAddr, oFourBit, oErrTiming);
    end
    test_ddram("reset_refill");
  endtask

  initial begin
    iMRst = 1'b1; iLcdEn = 1'b0; iLcdRegSel = 1'b0; iLcdRW = 1'b0; iLcdDb = 8'h00;
    iRdLine = 1'b0; iRdCol = 6'd0;
    validCnt = 0; busyCnt = 0; lastCmd = 9'h000;
    modelReset();
    test_reset();
    test_init();
    test_config();
    test_boundary();
    test_random();
    test_nib_timing();
    test_proto();
    test_reset_mid_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
